// File: rtl/reg_bank_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : reg_bank_ctrl
//  Description : Command-side master for a 2**AW x DW register bank.
//                Takes single READ/WRITE and block FILL/DUMP commands on a
//                valid/ready command port. Drives the bank's wr/addr/d inputs,
//                samples its combinational read data (q), and returns read
//                results on a valid/ready response port.
//  Ports       : clk, rst              - clock, synchronous active-high reset
//                cmd_valid/ready/op/addr/data - command port (op: 00 READ,
//                                        01 WRITE, 10 FILL, 11 DUMP)
//                rsp_valid/ready/data/addr/last - read response port
//                busy                  - controller not idle
//                bank_wr/addr/d        - drive the bank
//                bank_q                - bank read data (combinational)
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_bank_ctrl #(
   parameter int DW = 8,
   parameter int AW = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [1:0]    cmd_op,
   input  logic [AW-1:0] cmd_addr,
   input  logic [DW-1:0] cmd_data,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [DW-1:0] rsp_data,
   output logic [AW-1:0] rsp_addr,
   output logic          rsp_last,
   output logic          busy,
   output logic          bank_wr,
   output logic [AW-1:0] bank_addr,
   output logic [DW-1:0] bank_d,
   input  logic [DW-1:0] bank_q
);

   localparam logic [1:0]    C_OP_READ  = 2'b00;
   localparam logic [1:0]    C_OP_WRITE = 2'b01;
   localparam logic [1:0]    C_OP_FILL  = 2'b10;
   localparam logic [1:0]    C_OP_DUMP  = 2'b11;
   localparam logic [AW-1:0] C_LAST_IDX = '1;   // NREG-1

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_WRITE   = 3'd1,
      S_READ    = 3'd2,
      S_FILL    = 3'd3,
      S_DUMP_RD = 3'd4,
      S_RESP    = 3'd5
   } state_t;

   state_t        r_state;
   logic [1:0]    r_op;
   logic [AW-1:0] r_addr;
   logic [AW-1:0] r_idx;

   assign cmd_ready = (r_state == S_IDLE);
   assign busy      = (r_state != S_IDLE);

   // Bank drive signals are registered and loaded on entry to each state, so
   // the bank sees the new address/data for the whole of that state's cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_op      <= C_OP_READ;
         r_addr    <= '0;
         r_idx     <= '0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_addr  <= '0;
         rsp_last  <= 1'b0;
         bank_wr   <= 1'b0;
         bank_addr <= '0;
         bank_d    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (cmd_valid) begin
                  r_op   <= cmd_op;
                  r_addr <= cmd_addr;
                  r_idx  <= '0;
                  case (cmd_op)
                     C_OP_WRITE: begin
                        bank_wr   <= 1'b1;
                        bank_addr <= cmd_addr;
                        bank_d    <= cmd_data;
                        r_state   <= S_WRITE;
                     end
                     C_OP_READ: begin
                        bank_addr <= cmd_addr;
                        r_state   <= S_READ;
                     end
                     C_OP_FILL: begin
                        bank_wr   <= 1'b1;
                        bank_addr <= '0;
                        bank_d    <= cmd_data;
                        r_state   <= S_FILL;
                     end
                     default: begin
                        bank_addr <= '0;
                        r_state   <= S_DUMP_RD;
                     end
                  endcase
               end
            end
            S_WRITE: begin
               bank_wr <= 1'b0;
               r_state <= S_IDLE;
            end
            S_READ: begin
               rsp_data  <= bank_q;
               rsp_addr  <= r_addr;
               rsp_last  <= 1'b1;
               rsp_valid <= 1'b1;
               r_state   <= S_RESP;
            end
            S_FILL: begin
               // bank_d still holds the fill value loaded on acceptance.
               if (r_idx == C_LAST_IDX) begin
                  bank_wr <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_idx     <= r_idx + 1'b1;
                  bank_addr <= r_idx + 1'b1;
               end
            end
            S_DUMP_RD: begin
               rsp_data  <= bank_q;
               rsp_addr  <= r_idx;
               rsp_last  <= (r_idx == C_LAST_IDX);
               rsp_valid <= 1'b1;
               r_state   <= S_RESP;
            end
            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  if (r_op == C_OP_DUMP && !rsp_last) begin
                     r_idx     <= r_idx + 1'b1;
                     bank_addr <= r_idx + 1'b1;
                     r_state   <= S_DUMP_RD;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end
            end
            default: begin
               bank_wr <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_reg_bank_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_bank_ctrl
//  Description : Directed self-checking bench for reg_bank_ctrl with a small
//                behavioural 4 x 8-bit register bank attached.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_reg_bank_ctrl;

   localparam logic [1:0] OP_READ  = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_FILL  = 2'b10;
   localparam logic [1:0] OP_DUMP  = 2'b11;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic [1:0] cmd_addr;
   logic [7:0] cmd_data;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [7:0] rsp_data;
   logic [1:0] rsp_addr;
   logic       rsp_last;
   logic       busy;
   logic       bank_wr;
   logic [1:0] bank_addr;
   logic [7:0] bank_d;
   logic [7:0] bank_q;

   int passed = 0;
   int total  = 0;

   // Behavioural register bank: synchronous write, combinational read.
   logic [7:0] bank [4];
   always @(posedge clk) if (bank_wr) bank[bank_addr] <= bank_d;
   assign bank_q = bank[bank_addr];

   always #5 clk = ~clk;

   reg_bank_ctrl #(.DW(8), .AW(2)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_addr(cmd_addr), .cmd_data(cmd_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_addr(rsp_addr), .rsp_last(rsp_last), .busy(busy),
      .bank_wr(bank_wr), .bank_addr(bank_addr), .bank_d(bank_d), .bank_q(bank_q)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a command and hold it until accepted (bounded).
   task automatic issue(input logic [1:0] op, input logic [1:0] a, input logic [7:0] d);
      int n;
      n = 0;
      while (!cmd_ready && n < 30) begin
         tick();
         n++;
      end
      total++;
      if (!cmd_ready) $display("FAIL issue_ready: cmd_ready=%0b required 1 within 30 cycles", cmd_ready);
      else passed++;
      cmd_op = op; cmd_addr = a; cmd_data = d; cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(output int n);
      n = 0;
      while (!rsp_valid && n < 20) begin
         tick();
         n++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
      cmd_op = 2'b00; cmd_addr = 2'd0; cmd_data = 8'h00;
      tick(); tick();
      total++;
      if ({rsp_valid, rsp_data, rsp_addr, rsp_last, bank_wr, bank_addr, bank_d, busy, cmd_ready}
          !== {1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b1})
         $display("FAIL reset_values: got v=%0b d=%h a=%0d l=%0b wr=%0b ba=%0d bd=%h busy=%0b rdy=%0b required all 0, rdy=1",
                  rsp_valid, rsp_data, rsp_addr, rsp_last, bank_wr, bank_addr, bank_d, busy, cmd_ready);
      else passed++;
      rst = 1'b0;
      tick();
   endtask

   task automatic test_write();
      cmd_op = OP_WRITE; cmd_addr = 2'd2; cmd_data = 8'hA5; cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      total++;
      if ({bank_wr, bank_addr, bank_d, cmd_ready, rsp_valid} !== {1'b1, 2'd2, 8'hA5, 1'b0, 1'b0})
         $display("FAIL write_drive: got wr=%0b a=%0d d=%h rdy=%0b v=%0b required wr=1 a=2 d=a5 rdy=0 v=0",
                  bank_wr, bank_addr, bank_d, cmd_ready, rsp_valid);
      else passed++;
      tick();
      total++;
      if ({bank_wr, cmd_ready, rsp_valid} !== {1'b0, 1'b1, 1'b0})
         $display("FAIL write_done: got wr=%0b rdy=%0b v=%0b required wr=0 rdy=1 v=0", bank_wr, cmd_ready, rsp_valid);
      else passed++;
      total++;
      if (bank[2] !== 8'hA5) $display("FAIL write_bank: got %h required a5", bank[2]);
      else passed++;
   endtask

   task automatic test_read();
      issue(OP_WRITE, 2'd1, 8'h3C);
      rsp_ready = 1'b1;
      issue(OP_READ, 2'd1, 8'h00);
      total++;
      if ({rsp_valid, bank_wr, bank_addr} !== {1'b0, 1'b0, 2'd1})
         $display("FAIL read_cycle: got v=%0b wr=%0b a=%0d required v=0 wr=0 a=1", rsp_valid, bank_wr, bank_addr);
      else passed++;
      tick();
      total++;
      if ({rsp_valid, rsp_data, rsp_addr, rsp_last} !== {1'b1, 8'h3C, 2'd1, 1'b1})
         $display("FAIL read_rsp: got v=%0b d=%h a=%0d l=%0b required v=1 d=3c a=1 l=1",
                  rsp_valid, rsp_data, rsp_addr, rsp_last);
      else passed++;
      tick();
      total++;
      if ({rsp_valid, cmd_ready, busy} !== {1'b0, 1'b1, 1'b0})
         $display("FAIL read_idle: got v=%0b rdy=%0b busy=%0b required 0 1 0", rsp_valid, cmd_ready, busy);
      else passed++;
      rsp_ready = 1'b0;
   endtask

   task automatic test_fill_dump();
      int n;
      issue(OP_FILL, 2'd3, 8'h5A);
      for (int i = 0; i < 4; i++) begin
         total++;
         if ({bank_wr, bank_addr, bank_d} !== {1'b1, 2'(i), 8'h5A})
            $display("FAIL fill_cycle%0d: got wr=%0b a=%0d d=%h required wr=1 a=%0d d=5a", i, bank_wr, bank_addr, bank_d, i);
         else passed++;
         tick();
      end
      total++;
      if ({bank_wr, cmd_ready} !== {1'b0, 1'b1})
         $display("FAIL fill_end: got wr=%0b rdy=%0b required wr=0 rdy=1", bank_wr, cmd_ready);
      else passed++;
      total++;
      if ({bank[0], bank[1], bank[2], bank[3]} !== {4{8'h5A}})
         $display("FAIL fill_bank: got %h %h %h %h required 5a x4", bank[0], bank[1], bank[2], bank[3]);
      else passed++;
      rsp_ready = 1'b1;
      issue(OP_DUMP, 2'd2, 8'h00);
      for (int k = 0; k < 4; k++) begin
         wait_rsp(n);
         total++;
         if ({n[4:0], rsp_valid, rsp_data, rsp_addr, rsp_last} !== {5'd1, 1'b1, 8'h5A, 2'(k), (k == 3)})
            $display("FAIL dump_rsp%0d: got wait=%0d v=%0b d=%h a=%0d l=%0b required wait=1 v=1 d=5a a=%0d l=%0b",
                     k, n, rsp_valid, rsp_data, rsp_addr, rsp_last, k, (k == 3));
         else passed++;
         tick();
      end
      total++;
      if ({busy, rsp_valid, cmd_ready} !== {1'b0, 1'b0, 1'b1})
         $display("FAIL dump_end: got busy=%0b v=%0b rdy=%0b required 0 0 1", busy, rsp_valid, cmd_ready);
      else passed++;
      rsp_ready = 1'b0;
   endtask

   task automatic test_dump_stall();
      int n;
      logic [7:0] exp [4];
      exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33; exp[3] = 8'h44;
      for (int i = 0; i < 4; i++) issue(OP_WRITE, 2'(i), exp[i]);
      rsp_ready = 1'b0;
      issue(OP_DUMP, 2'd0, 8'h00);
      for (int k = 0; k < 4; k++) begin
         wait_rsp(n);
         for (int s = 0; s < 5; s++) begin
            total++;
            if ({rsp_valid, rsp_data, rsp_addr, rsp_last, cmd_ready, bank_wr}
                !== {1'b1, exp[k], 2'(k), (k == 3), 1'b0, 1'b0})
               $display("FAIL stall_hold%0d_%0d: got v=%0b d=%h a=%0d l=%0b rdy=%0b wr=%0b required v=1 d=%h a=%0d l=%0b rdy=0 wr=0",
                        k, s, rsp_valid, rsp_data, rsp_addr, rsp_last, cmd_ready, bank_wr, exp[k], k, (k == 3));
            else passed++;
            tick();
         end
         rsp_ready = 1'b1;
         tick();
         rsp_ready = 1'b0;
      end
      total++;
      if ({busy, rsp_valid} !== {1'b0, 1'b0})
         $display("FAIL stall_end: got busy=%0b v=%0b required 0 0", busy, rsp_valid);
      else passed++;
   endtask

   task automatic test_reset_mid_fill();
      issue(OP_FILL, 2'd0, 8'hFF);
      tick();
      total++;
      if ({bank_wr, bank_addr} !== {1'b1, 2'd1})
         $display("FAIL rfill_second: got wr=%0b a=%0d required wr=1 a=1", bank_wr, bank_addr);
      else passed++;
      rst = 1'b1;
      tick();
      total++;
      if ({rsp_valid, rsp_data, rsp_addr, rsp_last, bank_wr, bank_addr, bank_d, busy, cmd_ready}
          !== {1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b1})
         $display("FAIL rfill_reset: got v=%0b d=%h a=%0d l=%0b wr=%0b ba=%0d bd=%h busy=%0b rdy=%0b required all 0, rdy=1",
                  rsp_valid, rsp_data, rsp_addr, rsp_last, bank_wr, bank_addr, bank_d, busy, cmd_ready);
      else passed++;
      rst = 1'b0;
      tick(); tick();
      total++;
      if ({bank[0], bank[1], bank[2], bank[3], bank_wr, busy} !== {8'hFF, 8'hFF, 8'h33, 8'h44, 1'b0, 1'b0})
         $display("FAIL rfill_bank: got %h %h %h %h wr=%0b busy=%0b required ff ff 33 44 wr=0 busy=0",
                  bank[0], bank[1], bank[2], bank[3], bank_wr, busy);
      else passed++;
   endtask

   task automatic test_hold_cmd();
      int nwr;
      rsp_ready = 1'b0;
      cmd_op = OP_READ; cmd_addr = 2'd3; cmd_data = 8'h00; cmd_valid = 1'b1;
      tick();
      // Host now presents the next command and keeps it up while busy.
      cmd_op = OP_WRITE; cmd_addr = 2'd0; cmd_data = 8'h77;
      nwr = 0;
      for (int i = 0; i < 4; i++) begin
         total++;
         if (cmd_ready !== 1'b0) $display("FAIL hold_busy%0d: got rdy=%0b required 0", i, cmd_ready);
         else passed++;
         nwr += int'(bank_wr);
         tick();
      end
      total++;
      if ({rsp_valid, rsp_data, rsp_addr, rsp_last} !== {1'b1, 8'h44, 2'd3, 1'b1})
         $display("FAIL hold_rsp: got v=%0b d=%h a=%0d l=%0b required v=1 d=44 a=3 l=1",
                  rsp_valid, rsp_data, rsp_addr, rsp_last);
      else passed++;
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      total++;
      if ({cmd_ready, rsp_valid} !== {1'b1, 1'b0})
         $display("FAIL hold_idle: got rdy=%0b v=%0b required 1 0", cmd_ready, rsp_valid);
      else passed++;
      tick();
      cmd_valid = 1'b0;
      total++;
      if ({bank_wr, bank_addr, bank_d} !== {1'b1, 2'd0, 8'h77})
         $display("FAIL hold_accept: got wr=%0b a=%0d d=%h required wr=1 a=0 d=77", bank_wr, bank_addr, bank_d);
      else passed++;
      tick();
      for (int i = 0; i < 4; i++) begin
         nwr += int'(bank_wr);
         tick();
      end
      total++;
      if ({nwr[3:0], bank[0], busy} !== {4'd0, 8'h77, 1'b0})
         $display("FAIL hold_once: got extra_wr=%0d bank0=%h busy=%0b required 0 77 0", nwr, bank[0], busy);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_fill_dump();
      test_dump_stall();
      test_reset_mid_fill();
      test_hold_cmd();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
